// File: rtl/sw_debounce_pkg.sv
//==============================================================================
// Module  : sw_debounce_pkg
// Brief   : Shared types and default constants for the switch debouncer.
// Rev     : 1.0  initial release
//==============================================================================
`default_nettype none

package sw_debounce_pkg;

    typedef enum logic {
        S_STABLE = 1'b0,
        S_COUNT  = 1'b1
    } db_state_t;

    localparam int DB_CYCLES_DEF = 500000;
    localparam int DB_WIDTH_DEF  = 3;

endpackage : sw_debounce_pkg

`default_nettype wire

// File: rtl/sw_debounce_bit.sv
//==============================================================================
// Module  : sw_debounce_bit
// Brief   : One debounce channel: 2-flop synchroniser, stability FSM, counter.
// Rev     : 1.0  initial release
//==============================================================================
`default_nettype none

module sw_debounce_bit
    import sw_debounce_pkg::*;
#(
    parameter int   DEBOUNCE_CYCLES = DB_CYCLES_DEF,
    parameter logic RESET_VAL       = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic i_raw,
    output logic o_level,
    output logic o_chg
);

    localparam int                c_cnt_w    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [c_cnt_w-1:0] c_cnt_zero = '0;
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DEBOUNCE_CYCLES - 1);

    logic               r_ff1;
    logic               r_ff2;
    db_state_t          r_state;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_level;
    logic               r_chg;

    db_state_t          w_state_next;
    logic [c_cnt_w-1:0] w_cnt_next;
    logic               w_level_next;
    logic               w_chg_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ff1 <= RESET_VAL;
            r_ff2 <= RESET_VAL;
        end else begin
            r_ff1 <= i_raw;
            r_ff2 <= r_ff1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_STABLE;
            r_cnt   <= c_cnt_zero;
            r_level <= RESET_VAL;
            r_chg   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_level <= w_level_next;
            r_chg   <= w_chg_next;
        end
    end

    // The first mismatching sample already counts as 1, so the terminal
    // count is reached on the DEBOUNCE_CYCLES-th consecutive mismatch.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_level_next = r_level;
        case (r_state)
            S_STABLE: begin
                if (r_ff2 != r_level) begin
                    w_cnt_next   = c_cnt_one;
                    w_state_next = S_COUNT;
                end
            end
            S_COUNT: begin
                if (r_ff2 == r_level) begin
                    w_cnt_next   = c_cnt_zero;
                    w_state_next = S_STABLE;
                end else if (r_cnt == c_cnt_last) begin
                    w_level_next = r_ff2;
                    w_cnt_next   = c_cnt_zero;
                    w_state_next = S_STABLE;
                end else begin
                    w_cnt_next   = r_cnt + c_cnt_one;
                end
            end
            default: begin
                w_cnt_next   = c_cnt_zero;
                w_state_next = S_STABLE;
            end
        endcase
    end

    always_comb begin
        w_chg_next = w_level_next ^ r_level;
        o_level    = r_level;
        o_chg      = r_chg;
    end

endmodule : sw_debounce_bit

`default_nettype wire

// File: rtl/sw_debounce.sv
//==============================================================================
// Module  : sw_debounce
// Brief   : WIDTH-channel switch debouncer with change strobe.
//           Define SW_EDGE_EN to add per-bit rise_o / fall_o strobes.
// Rev     : 1.0  initial release
//==============================================================================
`default_nettype none

module sw_debounce
    import sw_debounce_pkg::*;
#(
    parameter int               WIDTH           = DB_WIDTH_DEF,
    parameter int               DEBOUNCE_CYCLES = DB_CYCLES_DEF,
    parameter logic [WIDTH-1:0] RESET_VAL       = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sw_raw_i,
    output logic [WIDTH-1:0] sw_o,
    output logic             chg_o
`ifdef SW_EDGE_EN
    ,
    output logic [WIDTH-1:0] rise_o,
    output logic [WIDTH-1:0] fall_o
`endif
);

    logic [WIDTH-1:0] w_chg;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        sw_debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .RESET_VAL       (RESET_VAL[i])
        ) u_bit (
            .clk     (clk),
            .rst     (rst),
            .i_raw   (sw_raw_i[i]),
            .o_level (sw_o[i]),
            .o_chg   (w_chg[i])
        );
    end

    assign chg_o = |w_chg;

`ifdef SW_EDGE_EN
    // Strobe and level are registered on the same edge, so the level
    // already holds the new value while the strobe is high.
    assign rise_o = w_chg & sw_o;
    assign fall_o = w_chg & ~sw_o;
`endif

endmodule : sw_debounce

`default_nettype wire

// File: tb/tb_sw_debounce.sv
//==============================================================================
// Module  : tb_sw_debounce
// Brief   : Directed self-checking bench for sw_debounce (DEBOUNCE_CYCLES=4).
//           Define SW_EDGE_EN to also exercise rise_o / fall_o.
// Rev     : 1.0  initial release
//==============================================================================
`default_nettype none

module tb_sw_debounce;

    localparam int c_width = 3;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic [c_width-1:0] sw_raw_i = '0;
    logic [c_width-1:0] sw_o;
    logic               chg_o;
`ifdef SW_EDGE_EN
    logic [c_width-1:0] rise_o;
    logic [c_width-1:0] fall_o;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    int chg_seen;

    sw_debounce #(
        .WIDTH           (c_width),
        .DEBOUNCE_CYCLES (4),
        .RESET_VAL       (3'b000)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .sw_raw_i (sw_raw_i),
        .sw_o     (sw_o),
        .chg_o    (chg_o)
`ifdef SW_EDGE_EN
        ,
        .rise_o   (rise_o),
        .fall_o   (fall_o)
`endif
    );

    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Advance one rising edge and settle 1 time unit past it.
    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        // 1: reset with all raw inputs high, then release
        #2 rst = 1'b1;
        sw_raw_i = 3'b111;
        step(2);
        check_value("t1_rst_sw", 32'(sw_o), 32'h0);
        check_value("t1_rst_chg", 32'(chg_o), 32'h0);
        rst = 1'b0;
        step(5);
        check_value("t1_edge5_sw", 32'(sw_o), 32'h0);
        step();
        check_value("t1_edge6_sw", 32'(sw_o), 32'h7);
        check_value("t1_edge6_chg", 32'(chg_o), 32'h1);
        step();
        check_value("t1_edge7_chg", 32'(chg_o), 32'h0);

        // 2: bouncing bit0 is rejected, steady 1 accepted with one strobe
        sw_raw_i = 3'b000;
        step(8);
        check_value("t2_clear_sw", 32'(sw_o), 32'h0);
        chg_seen = 0;
        for (int i = 0; i < 10; i++) begin
            sw_raw_i = {2'b00, ((i / 2) % 2) == 0};
            step();
            check_value("t2_bounce_sw", 32'(sw_o), 32'h0);
            chg_seen += int'(chg_o);
        end
        sw_raw_i = 3'b001;
        for (int i = 0; i < 3; i++) begin
            step();
            check_value("t2_hold_sw", 32'(sw_o), 32'h0);
            chg_seen += int'(chg_o);
        end
        step();
        check_value("t2_rise_sw", 32'(sw_o), 32'h1);
        chg_seen += int'(chg_o);
        step();
        chg_seen += int'(chg_o);
        check_value("t2_chg_pulses", 32'(chg_seen), 32'h1);

        // 3: bit2 then bit1 one cycle later
        sw_raw_i = 3'b101;
        step();
        sw_raw_i = 3'b111;
        step(4);
        check_value("t3_edge5_sw", 32'(sw_o), 32'h1);
        step();
        check_value("t3_bit2_sw", 32'(sw_o), 32'h5);
        check_value("t3_bit2_chg", 32'(chg_o), 32'h1);
        step();
        check_value("t3_bit1_sw", 32'(sw_o), 32'h7);
        check_value("t3_bit1_chg", 32'(chg_o), 32'h1);
        step();
        check_value("t3_after_chg", 32'(chg_o), 32'h0);

        // 4: reset pulse aborts an in-progress count on bit0
        sw_raw_i = 3'b000;
        step(8);
        check_value("t4_clear_sw", 32'(sw_o), 32'h0);
        sw_raw_i = 3'b001;
        step(4);
        rst = 1'b1;
        step();
        check_value("t4_rst_sw", 32'(sw_o), 32'h0);
        rst = 1'b0;
        step(5);
        check_value("t4_edge5_sw", 32'(sw_o), 32'h0);
        step();
        check_value("t4_edge6_sw", 32'(sw_o), 32'h1);
        check_value("t4_edge6_chg", 32'(chg_o), 32'h1);

        // 5: asynchronous reset between edges
        sw_raw_i = 3'b101;
        step(6);
        check_value("t5_pre_sw", 32'(sw_o), 32'h5);
        #2 rst = 1'b1;
        #1;
        check_value("t5_async_sw", 32'(sw_o), 32'h0);
        check_value("t5_async_chg", 32'(chg_o), 32'h0);
        step();
        rst = 1'b0;
        sw_raw_i = 3'b000;
        step(2);

`ifdef SW_EDGE_EN
        // 6: per-bit rise / fall strobes on bit1
        sw_raw_i = 3'b010;
        step(6);
        check_value("t6_rise_sw", 32'(sw_o), 32'h2);
        check_value("t6_rise", 32'(rise_o), 32'h2);
        check_value("t6_rise_fall", 32'(fall_o), 32'h0);
        check_value("t6_rise_chg", 32'(chg_o), 32'h1);
        step();
        check_value("t6_rise_end", 32'(rise_o), 32'h0);
        sw_raw_i = 3'b000;
        step(6);
        check_value("t6_fall_sw", 32'(sw_o), 32'h0);
        check_value("t6_fall", 32'(fall_o), 32'h2);
        check_value("t6_fall_rise", 32'(rise_o), 32'h0);
        check_value("t6_fall_chg", 32'(chg_o), 32'h1);
        step();
        check_value("t6_fall_end", 32'(fall_o), 32'h0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_sw_debounce

`default_nettype wire
